// File: rtl/mua_stream_encoder.sv
// rtl/mua_stream_encoder.sv - per-bin spike-count entropy encoder with MSB-first word packing
module mua_stream_encoder #(
  parameter int NUM_CH              = 4,
  parameter int SPIKE_RATE_BIT      = 3,
  parameter int NUM_SYM             = 5,
  parameter int ENCODER_NUM_BIT     = 2,
  parameter int MAX_CODEWORD_LENGTH = 4,
  parameter int LENGTH_WIDTH        = 3,
  parameter int OUT_W               = 16,
  localparam int SYM_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1,
  localparam int ENTRY_W = LENGTH_WIDTH + MAX_CODEWORD_LENGTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                bin_finish,
  input  logic [NUM_CH*SPIKE_RATE_BIT-1:0]    spike_number,
  input  logic [NUM_CH*ENCODER_NUM_BIT-1:0]   encoder_sel,
  input  logic                                cfg_we,
  input  logic [ENCODER_NUM_BIT-1:0]          cfg_table,
  input  logic [SYM_W-1:0]                    cfg_sym,
  input  logic [ENTRY_W-1:0]                  cfg_data,
  output logic [OUT_W-1:0]                    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun
);

  localparam int NUM_TABLES = 2 ** ENCODER_NUM_BIT;
  localparam int MAX_CL     = MAX_CODEWORD_LENGTH;
  localparam int SRB        = SPIKE_RATE_BIT;
  localparam int ENB        = ENCODER_NUM_BIT;
  localparam int ACC_W      = OUT_W + MAX_CL - 1;
  localparam int FILL_W     = $clog2(ACC_W + 1);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [SRB-1:0]          SAT_CNT = SRB'(NUM_SYM - 1);
  localparam logic [SYM_W-1:0]        SAT_SYM = SYM_W'(NUM_SYM - 1);
  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_CL);
  localparam logic [FILL_W-1:0]       FILL_OUT_W = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0]       FILL_ACC_W = FILL_W'(ACC_W);

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_EMIT, S_FLUSH} state_t;

  state_t                       state;
  logic [CH_W-1:0]              ch;
  logic [NUM_CH*SRB-1:0]        cnt_q;
  logic [NUM_CH*ENB-1:0]        sel_q;
  logic [ACC_W-1:0]             acc;
  logic [FILL_W-1:0]            fill;
  logic [ENTRY_W-1:0]           cb [NUM_TABLES][NUM_SYM];

  logic [SRB-1:0]               cnt_cur;
  logic [ENB-1:0]               sel_cur;
  logic [SYM_W-1:0]             sym_cur;
  logic [ENTRY_W-1:0]           entry;
  logic [LENGTH_WIDTH-1:0]      len_raw;
  logic [LENGTH_WIDTH-1:0]      len_eff;
  logic [MAX_CL-1:0]            cw_raw;
  logic [MAX_CL-1:0]            cw_m;
  logic [FILL_W-1:0]            fill_new;
  logic [FILL_W-1:0]            shamt;
  logic [ACC_W-1:0]             acc_app;
  logic [ACC_W-1:0]             acc_sh;
  logic [FILL_W-1:0]            fill_sh;

  // Power-on codebook: a short prefix-free code favouring low spike counts.
  function automatic logic [ENTRY_W-1:0] default_entry(input int sym);
    logic [LENGTH_WIDTH-1:0] l;
    logic [MAX_CL-1:0]       c;
    case (sym)
      0:       begin l = LENGTH_WIDTH'(1); c = MAX_CL'(1); end
      1:       begin l = LENGTH_WIDTH'(2); c = MAX_CL'(1); end
      2:       begin l = LENGTH_WIDTH'(3); c = MAX_CL'(1); end
      3:       begin l = LENGTH_WIDTH'(4); c = MAX_CL'(0); end
      4:       begin l = LENGTH_WIDTH'(4); c = MAX_CL'(1); end
      default: begin l = LENGTH_WIDTH'(1); c = MAX_CL'(0); end
    endcase
    return {l, c};
  endfunction

  // Codebook storage; programmable only while no bin is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TABLES; t++)
        for (int s = 0; s < NUM_SYM; s++)
          cb[t][s] <= default_entry(s);
    end else if (cfg_we && state == S_IDLE && ({1'b0, cfg_sym} < (SYM_W+1)'(NUM_SYM))) begin
      cb[cfg_table][cfg_sym] <= cfg_data;
    end
  end

  // Look up the current channel's codeword and form the appended/shifted accumulator.
  always_comb begin
    cnt_cur = cnt_q[int'(ch)*SRB +: SRB];
    sel_cur = sel_q[int'(ch)*ENB +: ENB];
    sym_cur = (cnt_cur >= SAT_CNT) ? SAT_SYM : SYM_W'(cnt_cur);
    entry   = cb[sel_cur][sym_cur];
    len_raw = entry[ENTRY_W-1 -: LENGTH_WIDTH];
    cw_raw  = entry[MAX_CL-1:0];
    // Oversized programmed lengths are clamped so the accumulator can never overflow.
    len_eff = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    cw_m    = '0;
    for (int i = 0; i < MAX_CL; i++)
      cw_m[i] = cw_raw[i] & (i < int'(len_eff));
    fill_new = fill + FILL_W'(len_eff);
    shamt    = FILL_ACC_W - fill_new;
    acc_app  = acc | (ACC_W'(cw_m) << shamt);
    acc_sh   = acc << OUT_W;
    fill_sh  = fill - FILL_OUT_W;
  end

  // Bin sequencing: snapshot, append one channel per cycle, emit full words, flush the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch        <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      acc       <= '0;
      fill      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bin_finish && state != S_IDLE)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bin_finish) begin
            cnt_q <= spike_number;
            sel_q <= encoder_sel;
            ch    <= '0;
            acc   <= '0;
            fill  <= '0;
            busy  <= 1'b1;
            state <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          acc  <= acc_app;
          fill <= fill_new;
          if (fill_new >= FILL_OUT_W) begin
            out_data  <= acc_app[ACC_W-1 -: OUT_W];
            out_valid <= 1'b1;
            out_last  <= (ch == LAST_CH) && (fill_new == FILL_OUT_W);
            state     <= S_EMIT;
          end else if (ch == LAST_CH) begin
            // An empty tail (all zero-length codes) presents nothing.
            out_data  <= acc_app[ACC_W-1 -: OUT_W];
            out_valid <= (fill_new != '0);
            out_last  <= (fill_new != '0);
            state     <= S_FLUSH;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            acc  <= acc_sh;
            fill <= fill_sh;
            if (ch == LAST_CH) begin
              if (fill_sh != '0) begin
                out_data  <= acc_sh[ACC_W-1 -: OUT_W];
                out_valid <= 1'b1;
                out_last  <= 1'b1;
                state     <= S_FLUSH;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              ch        <= ch + 1'b1;
              state     <= S_ENCODE;
            end
          end
        end
        S_FLUSH: begin
          if (!out_valid || out_ready) begin
            acc       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mua_stream_encoder.sv
// tb/tb_mua_stream_encoder.sv - self-checking bench for mua_stream_encoder (OUT_W=8)
module tb_mua_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bin_finish;
  logic [11:0] spike_number;
  logic [7:0]  encoder_sel;
  logic        cfg_we;
  logic [1:0]  cfg_table;
  logic [2:0]  cfg_sym;
  logic [6:0]  cfg_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  logic [3:0] m_cw  [4][5];
  int         m_len [4][5];

  typedef struct {
    logic [11:0] cnt;
    logic [7:0]  sel;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;
  vec_t vt [5];

  mua_stream_encoder #(
    .NUM_CH(4), .SPIKE_RATE_BIT(3), .NUM_SYM(5), .ENCODER_NUM_BIT(2),
    .MAX_CODEWORD_LENGTH(4), .LENGTH_WIDTH(3), .OUT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bin_finish(bin_finish),
    .spike_number(spike_number), .encoder_sel(encoder_sel),
    .cfg_we(cfg_we), .cfg_table(cfg_table), .cfg_sym(cfg_sym), .cfg_data(cfg_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      m_cw[t][0] = 4'b0001; m_len[t][0] = 1;
      m_cw[t][1] = 4'b0001; m_len[t][1] = 2;
      m_cw[t][2] = 4'b0001; m_len[t][2] = 3;
      m_cw[t][3] = 4'b0000; m_len[t][3] = 4;
      m_cw[t][4] = 4'b0001; m_len[t][4] = 4;
    end
  endtask

  // Reference: concatenate codeword bits into one bitstream, then cut into 8-bit words.
  task automatic build_expected(input logic [11:0] cnt, input logic [7:0] sel);
    bit bits[$];
    int c, s, t, n;
    logic [7:0] w;
    exp_data.delete();
    exp_last.delete();
    for (int k = 0; k < 4; k++) begin
      c = int'(cnt[k*3 +: 3]);
      s = (c > 4) ? 4 : c;
      t = int'(sel[k*2 +: 2]);
      for (int b = m_len[t][s] - 1; b >= 0; b--)
        bits.push_back(m_cw[t][s][b]);
    end
    n = bits.size();
    for (int i = 0; i < n; i += 8) begin
      w = '0;
      for (int j = 0; j < 8; j++)
        if (i + j < n) w[7-j] = bits[i+j];
      exp_data.push_back(w);
      exp_last.push_back(i + 8 >= n);
    end
  endtask

  task automatic check_got(input string name);
    int n;
    chk({name, "_nwords"}, got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", name, i), {24'd0, got_data[i]}, {24'd0, exp_data[i]});
      chk($sformatf("%s_l%0d", name, i), {31'd0, got_last[i]}, {31'd0, exp_last[i]});
    end
  endtask

  task automatic cfg_write(input logic [1:0] t, input logic [2:0] s, input logic [2:0] l, input logic [3:0] c);
    cfg_we = 1'b1; cfg_table = t; cfg_sym = s; cfg_data = {l, c};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_bin(input logic [11:0] cnt, input logic [7:0] sel, input bit rnd, input bit cfg_busy);
    int cyc;
    got_data.delete();
    got_last.delete();
    spike_number = cnt;
    encoder_sel  = sel;
    bin_finish   = 1'b1;
    out_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    bin_finish = 1'b0;
    if (cfg_busy) begin
      cfg_we = 1'b1; cfg_table = 2'd1; cfg_sym = 3'd0; cfg_data = {3'd1, 4'b0001};
      tick();
      cfg_we = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL bin_timeout: busy still high after %0d cycles", cyc);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    logic [11:0] rc;
    logic [7:0]  rs;

    vt[0] = '{cnt: {3'd3, 3'd2, 3'd1, 3'd0}, sel: 8'h00, nw: 2, w0: 8'b10100100, w1: 8'h00};
    vt[1] = '{cnt: {3'd0, 3'd5, 3'd4, 3'd7}, sel: 8'h00, nw: 2, w0: 8'b00010001, w1: 8'b00011000};
    vt[2] = '{cnt: {3'd4, 3'd4, 3'd4, 3'd4}, sel: 8'hFF, nw: 2, w0: 8'h11, w1: 8'h11};
    vt[3] = '{cnt: {3'd0, 3'd0, 3'd0, 3'd0}, sel: 8'h1B, nw: 1, w0: 8'hF0, w1: 8'h00};
    vt[4] = '{cnt: {3'd2, 3'd2, 3'd2, 3'd2}, sel: 8'h00, nw: 2, w0: 8'h24, w1: 8'h90};

    rst_n = 1'b0; bin_finish = 1'b0; spike_number = '0; encoder_sel = '0;
    cfg_we = 1'b0; cfg_table = '0; cfg_sym = '0; cfg_data = '0; out_ready = 1'b1;
    model_reset();
    tick(); tick();
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Default-table vectors.
    for (int v = 0; v < 5; v++) begin
      exp_data.delete(); exp_last.delete();
      exp_data.push_back(vt[v].w0);
      exp_last.push_back(vt[v].nw == 1);
      if (vt[v].nw == 2) begin
        exp_data.push_back(vt[v].w1);
        exp_last.push_back(1'b1);
      end
      run_bin(vt[v].cnt, vt[v].sel, 1'b0, 1'b0);
      check_got($sformatf("vec%0d", v));
    end

    // Out-of-range symbol write must not disturb anything.
    cfg_write(2'd0, 3'd5, 3'd2, 4'b0011);
    // Table 1 sym0 becomes '0'/1; ch2 selects it.
    cfg_write(2'd1, 3'd0, 3'd1, 4'b0000);
    m_cw[1][0] = 4'b0000; m_len[1][0] = 1;
    exp_data.delete(); exp_last.delete();
    exp_data.push_back(8'hD0); exp_last.push_back(1'b1);
    run_bin(12'd0, {2'd0, 2'd1, 2'd0, 2'd0}, 1'b0, 1'b0);
    check_got("cfg_t1s0");
    // Same bin with a write attempted mid-bin; codebook must be unchanged afterwards.
    run_bin(12'd0, {2'd0, 2'd1, 2'd0, 2'd0}, 1'b0, 1'b1);
    run_bin(12'd0, {2'd0, 2'd1, 2'd0, 2'd0}, 1'b0, 1'b0);
    check_got("cfg_busy_drop");
    exp_data.delete(); exp_last.delete();
    exp_data.push_back(8'hA4); exp_last.push_back(1'b0);
    exp_data.push_back(8'h00); exp_last.push_back(1'b1);
    run_bin({3'd3, 3'd2, 3'd1, 3'd0}, 8'h00, 1'b0, 1'b0);
    check_got("oor_sym_ignored");

    // Backpressure stall with an overlapping bin_finish.
    got_data.delete(); got_last.delete();
    out_ready = 1'b0;
    spike_number = {3'd3, 3'd2, 3'd1, 3'd0};
    encoder_sel = 8'h00;
    bin_finish = 1'b1;
    tick();
    bin_finish = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin tick(); cyc++; end
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_data%0d", i), {24'd0, out_data}, 32'hA4);
      chk($sformatf("stall_last%0d", i), {31'd0, out_last}, 32'd0);
      bin_finish = (i == 2);
      tick();
    end
    bin_finish = 1'b0;
    chk("stall_overrun", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 50) begin tick(); cyc++; end
    for (int i = 0; i < 5; i++) tick();
    chk("stall_idle", {31'd0, busy}, 32'd0);
    exp_data.delete(); exp_last.delete();
    exp_data.push_back(8'hA4); exp_last.push_back(1'b0);
    exp_data.push_back(8'h00); exp_last.push_back(1'b1);
    check_got("stall_one_bin");

    // Zero-length codes: exact-fill single word, then an all-empty bin.
    cfg_write(2'd2, 3'd0, 3'd0, 4'b0000);
    m_cw[2][0] = 4'b0000; m_len[2][0] = 0;
    exp_data.delete(); exp_last.delete();
    exp_data.push_back(8'h00); exp_last.push_back(1'b1);
    run_bin({3'd3, 3'd3, 3'd0, 3'd0}, {2'd0, 2'd0, 2'd2, 2'd2}, 1'b0, 1'b0);
    check_got("exact_fill");
    exp_data.delete(); exp_last.delete();
    run_bin(12'd0, 8'hAA, 1'b0, 1'b0);
    check_got("all_empty");

    // Randomised bins against the bitstream model, with random codebook writes and backpressure.
    for (int r = 0; r < 40; r++) begin
      if (r % 4 == 0) begin
        logic [2:0] rsym, rlen;
        logic [3:0] rcw;
        rsym = 3'($urandom_range(0, 4));
        rlen = 3'($urandom_range(0, 4));
        rcw  = 4'($urandom_range(0, 15));
        cfg_write(2'd3, rsym, rlen, rcw);
        m_cw[3][rsym] = rcw;
        m_len[3][rsym] = int'(rlen);
      end
      rc = 12'($urandom);
      rs = 8'($urandom);
      build_expected(rc, rs);
      run_bin(rc, rs, 1'b1, 1'b0);
      check_got($sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of a bin.
    spike_number = 12'hFFF;
    encoder_sel = 8'h00;
    bin_finish = 1'b1;
    tick();
    bin_finish = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    build_expected({3'd3, 3'd2, 3'd1, 3'd0}, {2'd3, 2'd3, 2'd1, 2'd2});
    chk("arst_model_w0", {24'd0, exp_data[0]}, 32'hA4);
    run_bin({3'd3, 3'd2, 3'd1, 3'd0}, {2'd3, 2'd3, 2'd1, 2'd2}, 1'b0, 1'b0);
    check_got("post_reset_defaults");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mua_stream_encoder.md
# mua_stream_encoder

Multi-channel, parametrised entropy encoder for per-bin spike counts. On each bin boundary it snapshots the counts and table selections of all channels, encodes them one channel per cycle through a run-time-programmable codebook, and packs the variable-length codewords MSB-first into fixed-width output words. Output words leave on a valid/ready stream. The block sits between the spike binning/mapping stage and the link serialiser.

## Interface
- NUM_CH, 4: channels encoded per bin.
- SPIKE_RATE_BIT, 3: width of each channel's spike count.
- NUM_SYM, 5: codebook symbols per table; counts ≥ NUM_SYM-1 map to symbol NUM_SYM-1. Constraint: NUM_SYM ≤ 2^SPIKE_RATE_BIT.
- ENCODER_NUM_BIT, 2: table-select width; number of tables is 2^ENCODER_NUM_BIT.
- MAX_CODEWORD_LENGTH, 4: maximum codeword bits.
- LENGTH_WIDTH, 3: codeword-length field width. Must hold MAX_CODEWORD_LENGTH.
- OUT_W, 16: packed output word width. Constraint: OUT_W ≥ MAX_CODEWORD_LENGTH.
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- bin_finish, input, 1: one-cycle pulse marking the end of a bin.
- spike_number, input, NUM_CH·SPIKE_RATE_BIT: flattened counts; channel 0 in the LSBs.
- encoder_sel, input, NUM_CH·ENCODER_NUM_BIT: flattened per-channel table select; channel 0 in the LSBs.
- cfg_we, input, 1: codebook write strobe.
- cfg_table, input, ENCODER_NUM_BIT: table index for the write.
- cfg_sym, input, clog2(NUM_SYM): symbol index for the write.
- cfg_data, input, LENGTH_WIDTH+MAX_CODEWORD_LENGTH: {length, codeword}; codeword is right-aligned.
- out_data, output, OUT_W: packed word; the first-encoded bit is in the MSB.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the word.
- out_last, output, 1: marks the final word of a bin.
- busy, output, 1: a bin is being encoded or flushed.
- overrun, output, 1: sticky flag; a bin_finish arrived while busy.

## Operation
- Codebook: 2^ENCODER_NUM_BIT × NUM_SYM entries of {length, codeword}.
  - Reset contents for every table: sym0 = '1'/1, sym1 = '01'/2, sym2 = '001'/3, sym3 = '0000'/4, sym4 = '0001'/4. Any other symbols reset to '0'/1.
  - Writes take effect only in IDLE. A cfg_we while busy is dropped.
  - A length of 0 is legal; that symbol emits no bits.
  - Out-of-range cfg_sym (≥ NUM_SYM) is ignored.
- Symbol = min(spike_number[ch], NUM_SYM-1). Only the low `length` bits of the codeword are emitted, MSB of those first.
- FSM states: IDLE, ENCODE, EMIT, FLUSH.
  - IDLE: when bin_finish is seen, latch all counts and selects, set ch=0, go to ENCODE, assert busy.
  - ENCODE: append channel ch's codeword to the accumulator (width OUT_W+MAX_CODEWORD_LENGTH-1) and increment fill by length.
    - If the new fill ≥ OUT_W, go to EMIT.
    - Otherwise, if ch = NUM_CH-1, go to FLUSH.
    - Otherwise ch++ and stay in ENCODE.
  - EMIT: out_data = top OUT_W bits, out_valid=1. out_last=1 iff the last channel is already appended and the remaining fill is 0. Hold until out_ready.
    - On acceptance: shift the remainder up and fill -= OUT_W.
    - Then: if the last channel is done, go to FLUSH when fill>0, else go to IDLE. Otherwise ch++ and return to ENCODE.
  - FLUSH: emit the remaining fill bits MSB-aligned, zero-padded, with out_last=1. On acceptance clear fill and go to IDLE.
- A bin_finish while busy: the bin is discarded and overrun is set. overrun is cleared only by reset.
- A bin whose codewords are all zero-length emits nothing and returns to IDLE with no out_last.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, fill=0, ch=0, state=IDLE, codebook = default contents.
- bin_finish at cycle T → first ENCODE at T+1. Each channel takes one cycle, plus cycles in EMIT and FLUSH.
- All outputs are registered. out_valid rises the cycle after the triggering append.
- Stream rules:
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - A transfer occurs when out_valid and out_ready are both high on a clock edge.
  - The next word can be presented, at the earliest, one cycle after the transfer.
- busy deasserts the cycle after the final transfer. A bin_finish in that same cycle is accepted.
- Best case, no backpressure: the bin completes in NUM_CH + number-of-words + 1 cycles.
- Reset asserted mid-bin: the FSM returns immediately to IDLE, no partial word is emitted, and the codebook returns to its defaults.

## Test plan
- Default table, OUT_W=8, counts {0,1,2,3} (ch0..3), ready=1 → words 8'b10100100, then 8'b00000000 with out_last=1.
- Counts {7,4,5,0}, all sel=0 → saturation to sym4: bitstream 0001 0001 0001 1 → words 8'b00010001, 8'b00011000 (last).
- Write table1 sym0 = '0'/1, set ch2 sel=1 with count 0 → exactly 1 bit '0' at ch2's position. The same write attempted while busy is ignored.
- Hold out_ready=0 for 5 cycles during EMIT → out_data and out_last stay constant. Pulse bin_finish during that stall → overrun=1 and exactly one bin is output.
- Exact fill: OUT_W=8, counts {3,3,…} using two 4-bit codes → single word 8'b00000000 with out_last=1 and no FLUSH word.
- Deassert rst_n mid-ENCODE → all outputs return to reset values asynchronously. The next bin encodes correctly with the default table.
